cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
Control unit for the Simple-CPU datapath. It latches a 9-bit instruction and steps a 2-bit time-step counter through T0..T3. Each step drives the bus-mux selects, register-load enables, ALU add/sub and done strobes. Register-field decoding to one-hot Rin/Rout selects reuses a small one-hot decoder sub-module.

Parameters:
IR_W, 9, instruction width: opcode[8:6], X field[5:3], Y field[2:0]
NUM_REGS, 8, general registers R0..R7; Rin/Rout width

Ports:
clk  input  1  system clock; all state updates on rising edge
resetn  input  1  synchronous, active-low reset
run  input  1  start request; sampled only in T0
din  input  IR_W  instruction/immediate word from the data input bus
ir_in  output  1  load instruction register (T0)
rin  output  NUM_REGS  one-hot register load enable
rout  output  NUM_REGS  one-hot register bus-drive select
din_out  output  1  drive din onto the bus
g_out  output  1  drive G (ALU result) onto the bus
a_in  output  1  load A register
g_in  output  1  load G register
add_sub  output  1  0 = add, 1 = subtract
done  output  1  instruction complete strobe
step  output  4  one-hot current time step: bit0 = T0 .. bit3 = T3
ir  output  IR_W  latched instruction

Behaviour:
- State: tstep[1:0], ir[IR_W-1:0]. Reset (resetn=0 at an edge): tstep=T0, ir=0.
- While resetn=0, all control outputs are forced 0 combinationally, including step. After reset: step=4'b0001.
- Reset mid-instruction abandons the instruction. The next cycle is T0 and no done is emitted.
- Control outputs are combinational from (tstep, ir, run). This gives zero latency within a step.
- T0:
  - ir_in = run.
  - When run=1, ir <= din and tstep <= T1 at the edge.
  - When run=0, tstep stays T0 and ir holds.
- Opcodes (ir[8:6]), decX/decY = one-hot of ir[5:3] / ir[2:0]:
  - 000 mv Rx,Ry: T1: rout=decY, rin=decX, done=1.
  - 001 mvi Rx,#D: T1: din_out=1, rin=decX, done=1. The immediate is the din word present during T1.
  - 010 add Rx,Ry:
    - T1: rout=decX, a_in=1.
    - T2: rout=decY, g_in=1, add_sub=0.
    - T3: g_out=1, rin=decX, done=1.
  - 011 sub Rx,Ry: same as add, except add_sub=1 in T2. add_sub=0 in all other steps.
  - 100..111 reserved: T1: done=1 only (NOP).
- Step advance:
  - done=1 → tstep <= T0 next edge.
  - Otherwise T1→T2→T3.
  - T3 always asserts done, so no wrap past T3. A stuck T3 cannot occur.
- run is ignored outside T0. Deasserting run mid-instruction does not stall or abort.
- ir changes only in T0 with run=1. It is stable for the whole execution.
- Back-to-back: run held 1 → the instruction following done is fetched in the cycle immediately after done (T0).
- At most one of rout/din_out/g_out is nonzero per cycle (bus exclusivity). rin and rout are each 0 or one-hot.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - step constants T0..T3.
  - IR field bit positions.
- Sub-module reg_sel_decoder: 3-bit binary in → 8-bit one-hot out, purely combinational. It is instantiated twice, for the X and Y fields.

Test Plan:
- Reset: resetn=0 for 2 cycles with run=1 → all outputs 0. After release, step=0001 and ir=0.
- mvi R2: din=9'b001_010_000, run=1.
  - Cycle0: ir_in=1.
  - Cycle1: din_out=1, rin=8'b00000100, done=1.
  - Cycle2: step=0001.
- add R1,R3: din=9'b010_001_011.
  - T1: rout=00000010, a_in=1.
  - T2: rout=00001000, g_in=1, add_sub=0.
  - T3: g_out=1, rin=00000010, done=1.
- sub R7,R0 with run dropped after T0: din=9'b011_111_000.
  - Full 4-step sequence completes, with add_sub=1 only in T2 and rin=10000000 in T3.
  - Then tstep holds in T0.
- Reset mid-op: assert resetn=0 during T2 of an add → next cycle is T0, no g_out/done pulse, ir=0. Reserved opcode 9'b110_000_000 → T1 done=1, all other outputs 0.
- Back-to-back with run held: mv R0,R5 followed by mvi R4 → done in consecutive T1s, with exactly one T0 between them. Assert bus-exclusivity and one-hot rin/rout on every cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Simple-CPU control path: opcodes, time steps and
// instruction field positions.
package cpu_pkg;

    localparam int CPU_IR_W     = 9;
    localparam int CPU_NUM_REGS = 8;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int X_MSB   = 5;
    localparam int X_LSB   = 3;
    localparam int Y_MSB   = 2;
    localparam int Y_LSB   = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_t;

endpackage

// File: rtl/reg_sel_decoder.sv
// 3-bit register number to 8-bit one-hot select, purely combinational.
module reg_sel_decoder (
    input  logic [2:0] sel_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = 8'b0000_0001 << sel_i;

endmodule

// File: rtl/cpu_control_sequencer.sv
// Control unit for the Simple-CPU datapath: latches an instruction in T0 and
// sequences bus selects, register loads and ALU control through T1..T3.
//
// state | meaning
// T0    | idle / fetch: ir_in = run, load ir on run
// T1    | mv/mvi complete, add/sub load A, reserved opcodes finish as NOP
// T2    | add/sub: operand Y onto bus, load G
// T3    | add/sub: G onto bus, write Rx, done
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int IR_W     = CPU_IR_W,
    parameter int NUM_REGS = CPU_NUM_REGS
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                run,
    input  logic [IR_W-1:0]     din,
    output logic                ir_in,
    output logic [NUM_REGS-1:0] rin,
    output logic [NUM_REGS-1:0] rout,
    output logic                din_out,
    output logic                g_out,
    output logic                a_in,
    output logic                g_in,
    output logic                add_sub,
    output logic                done,
    output logic [3:0]          step,
    output logic [IR_W-1:0]     ir
);

    tstep_t          tstep_q, tstep_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0]          opcode;
    logic [NUM_REGS-1:0] dec_x, dec_y;

    logic ir_in_c, rin_x_c, rout_x_c, rout_y_c;
    logic din_out_c, g_out_c, a_in_c, g_in_c, add_sub_c, done_c;

    assign opcode = ir_q[OPC_MSB:OPC_LSB];

    reg_sel_decoder u_dec_x (
        .sel_i    (ir_q[X_MSB:X_LSB]),
        .onehot_o (dec_x)
    );

    reg_sel_decoder u_dec_y (
        .sel_i    (ir_q[Y_MSB:Y_LSB]),
        .onehot_o (dec_y)
    );

    always_comb begin
        tstep_d   = tstep_q;
        ir_d      = ir_q;
        ir_in_c   = 1'b0;
        rin_x_c   = 1'b0;
        rout_x_c  = 1'b0;
        rout_y_c  = 1'b0;
        din_out_c = 1'b0;
        g_out_c   = 1'b0;
        a_in_c    = 1'b0;
        g_in_c    = 1'b0;
        add_sub_c = 1'b0;
        done_c    = 1'b0;

        unique case (tstep_q)
            T0: begin
                ir_in_c = run;
                if (run) begin
                    ir_d    = din;
                    tstep_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_y_c = 1'b1;
                        rin_x_c  = 1'b1;
                        done_c   = 1'b1;
                    end
                    OP_MVI: begin
                        din_out_c = 1'b1;
                        rin_x_c   = 1'b1;
                        done_c    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_x_c = 1'b1;
                        a_in_c   = 1'b1;
                    end
                    default: done_c = 1'b1;
                endcase
            end
            T2: begin
                rout_y_c  = 1'b1;
                g_in_c    = 1'b1;
                add_sub_c = (opcode == OP_SUB);
            end
            T3: begin
                g_out_c = 1'b1;
                rin_x_c = 1'b1;
                done_c  = 1'b1;
            end
        endcase

        if (tstep_q != T0)
            tstep_d = done_c ? T0 : tstep_t'(tstep_q + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tstep_q <= T0;
            ir_q    <= '0;
        end else begin
            tstep_q <= tstep_d;
            ir_q    <= ir_d;
        end
    end

    // Reset masks every output immediately, not just from the next edge.
    assign ir_in   = resetn & ir_in_c;
    assign rin     = (resetn && rin_x_c) ? dec_x : '0;
    assign rout    = !resetn  ? '0 :
                     rout_x_c ? dec_x :
                     rout_y_c ? dec_y : '0;
    assign din_out = resetn & din_out_c;
    assign g_out   = resetn & g_out_c;
    assign a_in    = resetn & a_in_c;
    assign g_in    = resetn & g_in_c;
    assign add_sub = resetn & add_sub_c;
    assign done    = resetn & done_c;
    assign step    = resetn ? (4'b0001 << tstep_q) : 4'b0000;
    assign ir      = resetn ? ir_q : '0;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench: per-cycle expected output words are queued as stimulus
// is driven and compared against the DUT once its outputs settle.
module tb_cpu_control_sequencer;

    logic       clk = 1'b0;
    logic       resetn, run;
    logic [8:0] din;
    logic       ir_in, din_out, g_out, a_in, g_in, add_sub, done;
    logic [7:0] rin, rout;
    logic [3:0] step;
    logic [8:0] ir;

    int n_checks = 0;
    int n_passed = 0;

    logic [35:0] exp_q[$];

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_DIN  = 6'b100000;
    localparam logic [5:0] F_GOUT = 6'b010000;
    localparam logic [5:0] F_AIN  = 6'b001000;
    localparam logic [5:0] F_GIN  = 6'b000100;
    localparam logic [5:0] F_SUB  = 6'b000010;
    localparam logic [5:0] F_DONE = 6'b000001;

    always #5 clk = ~clk;

    cpu_control_sequencer dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .din     (din),
        .ir_in   (ir_in),
        .rin     (rin),
        .rout    (rout),
        .din_out (din_out),
        .g_out   (g_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .done    (done),
        .step    (step),
        .ir      (ir)
    );

    function automatic logic [35:0] ev(input logic ir_in_e, input logic [7:0] rin_e,
                                       input logic [7:0] rout_e, input logic [5:0] f,
                                       input logic [3:0] step_e, input logic [8:0] ir_e);
        return {ir_in_e, rin_e, rout_e, f, step_e, ir_e};
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_checks++;
        if (got === want) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare.
    task automatic cyc(input string tag, input logic rn, input logic r, input logic [8:0] d,
                       input logic [35:0] want);
        logic [35:0] got, e;
        int bus_drivers;
        @(negedge clk);
        resetn = rn;
        run    = r;
        din    = d;
        exp_q.push_back(want);
        #1;
        got = {ir_in, rin, rout, din_out, g_out, a_in, g_in, add_sub, done, step, ir};
        e = exp_q.pop_front();
        check(tag, got, e);
        bus_drivers = int'(rout != 8'h00) + int'(din_out) + int'(g_out);
        check({tag, "_bus_excl"}, 36'(bus_drivers <= 1), 36'd1);
        check({tag, "_onehot"}, 36'($onehot0(rin) && $onehot0(rout)), 36'd1);
    endtask

    initial begin
        resetn = 1'b0;
        run    = 1'b1;
        din    = 9'h1FF;

        cyc("rst0", 1'b0, 1'b1, 9'h1FF, ev(0, 8'h00, 8'h00, F_NONE, 4'b0000, 9'h000));
        cyc("rst1", 1'b0, 1'b1, 9'h1FF, ev(0, 8'h00, 8'h00, F_NONE, 4'b0000, 9'h000));
        cyc("idle", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h000));

        // mvi R2
        cyc("mvi_t0", 1'b1, 1'b1, 9'b001_010_000, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h000));
        cyc("mvi_t1", 1'b1, 1'b0, 9'h005, ev(0, 8'h04, 8'h00, F_DIN | F_DONE, 4'b0010, 9'h050));
        cyc("mvi_end", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h050));

        // add R1,R3
        cyc("add_t0", 1'b1, 1'b1, 9'b010_001_011, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h050));
        cyc("add_t1", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h02, F_AIN, 4'b0010, 9'h08B));
        cyc("add_t2", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h08, F_GIN, 4'b0100, 9'h08B));
        cyc("add_t3", 1'b1, 1'b0, 9'h000, ev(0, 8'h02, 8'h00, F_GOUT | F_DONE, 4'b1000, 9'h08B));
        cyc("add_end", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h08B));

        // sub R7,R0, run dropped after T0 (run raised in T1 must be ignored)
        cyc("sub_t0", 1'b1, 1'b1, 9'b011_111_000, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h08B));
        cyc("sub_t1", 1'b1, 1'b1, 9'h1FF, ev(0, 8'h00, 8'h80, F_AIN, 4'b0010, 9'h0F8));
        cyc("sub_t2", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h01, F_GIN | F_SUB, 4'b0100, 9'h0F8));
        cyc("sub_t3", 1'b1, 1'b0, 9'h000, ev(0, 8'h80, 8'h00, F_GOUT | F_DONE, 4'b1000, 9'h0F8));
        cyc("sub_hold0", 1'b1, 1'b0, 9'h1FF, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h0F8));
        cyc("sub_hold1", 1'b1, 1'b0, 9'h1FF, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h0F8));

        // reset during T2 of add
        cyc("abort_t0", 1'b1, 1'b1, 9'b010_001_011, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h0F8));
        cyc("abort_t1", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h02, F_AIN, 4'b0010, 9'h08B));
        cyc("abort_rst", 1'b0, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0000, 9'h000));
        cyc("abort_after", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h000));

        // reserved opcode
        cyc("rsv_t0", 1'b1, 1'b1, 9'b110_000_000, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h000));
        cyc("rsv_t1", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_DONE, 4'b0010, 9'h180));
        cyc("rsv_end", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h180));

        // back-to-back mv R0,R5 then mvi R4 with run held
        cyc("b2b_t0a", 1'b1, 1'b1, 9'b000_000_101, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h180));
        cyc("b2b_t1a", 1'b1, 1'b1, 9'b001_100_000, ev(0, 8'h01, 8'h20, F_DONE, 4'b0010, 9'h005));
        cyc("b2b_t0b", 1'b1, 1'b1, 9'b001_100_000, ev(1, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h005));
        cyc("b2b_t1b", 1'b1, 1'b0, 9'h1FF, ev(0, 8'h10, 8'h00, F_DIN | F_DONE, 4'b0010, 9'h060));
        cyc("b2b_end", 1'b1, 1'b0, 9'h000, ev(0, 8'h00, 8'h00, F_NONE, 4'b0001, 9'h060));

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
